hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage RISC-V core. It sits beside stage_ID and performs four jobs:
- generates the forward selects for the ID-stage operand muxes (forward_comp1/2);
- detects load-use hazards and inserts bubbles;
- freezes the pipeline while data memory is not ready, and converts taken branches into IF/ID flushes;
- sequences a boot hold after reset, counts wait cycles with a timeout, and keeps saturating stall/flush performance counters.

## Interface
- REG_ADDR_WIDTH, 5, register address width
- BOOT_CYCLES, 2, cycles the front end is held after reset release (≥1)
- MEM_TIMEOUT, 255, max consecutive dmem wait cycles before error
- CNT_WIDTH, 32, performance counter width

Ports:
- clk  in  1  clock; one clock domain
- reset_n  in  1  asynchronous, active-low reset
- IF_ID_rs1 / IF_ID_rs2  in  REG_ADDR_WIDTH  ID source registers
- id_uses_rs1 / id_uses_rs2  in  1  ID instruction reads rs1/rs2
- ID_EX_reg_wr_en, ID_EX_is_load  in  1  EX-stage producer info
- ID_EX_rd  in  REG_ADDR_WIDTH  EX-stage destination
- EX_MEM_reg_wr_en, EX_MEM_is_load, EX_MEM_mem_req  in  1  MEM-stage producer / memory access
- EX_MEM_rd  in  REG_ADDR_WIDTH  MEM-stage destination
- dmem_ready  in  1  data memory completes the access this cycle
- pc_sel  in  1  taken branch/jump resolved in ID
- pc_write  out  1  PC update enable
- IF_ID_write  out  1  IF/ID register enable
- ID_EX_bubble  out  1  load NOP into ID/EX
- if_id_flush  out  1  squash IF/ID
- pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
- forward_comp1 / forward_comp2  out  2  ID operand select
- mem_timeout_err  out  1  sticky timeout flag
- stall_cnt / flush_cnt  out  CNT_WIDTH  performance counters

## Operation

**Forward encoding** (identical for both operands): 00 register file, 01 alu_out, 10 DMEM_data_out, 11 EX_MEM_alu_out. stage_ID's data_out_2 leg 11 is rewired to EX_MEM_alu_out. WB-stage producers are covered by reg_file write-before-read; this block does not forward them.

**Per-operand select priority:**
1. rs == 0 → 00.
2. ID_EX_reg_wr_en & !ID_EX_is_load & ID_EX_rd == rs → 01.
3. EX_MEM_reg_wr_en & EX_MEM_rd == rs → 10 if EX_MEM_is_load, else 11.
4. Otherwise → 00.

**Load-use:** load_use = ID_EX_is_load & ID_EX_reg_wr_en & ID_EX_rd ≠ 0 & ((id_uses_rs1 & rs1 == ID_EX_rd) | (id_uses_rs2 & rs2 == ID_EX_rd)).

**Memory stall:** mem_stall = EX_MEM_mem_req & !dmem_ready.

**FSM states:** BOOT, RUN, MEM_WAIT.

BOOT:
- outputs: pc_write = 0, IF_ID_write = 0, ID_EX_bubble = 1, if_id_flush = 0, pipe_freeze = 0, forwards = 00.
- boot_cnt counts from 0; transition to RUN when boot_cnt == BOOT_CYCLES-1.

RUN and MEM_WAIT, with priority mem_stall > load_use > pc_sel:
- pipe_freeze = mem_stall.
- pc_write = IF_ID_write = !mem_stall & !load_use.
- ID_EX_bubble = !mem_stall & load_use.
- if_id_flush = pc_sel & !mem_stall & !load_use. A branch waiting on a load is stalled first, then re-evaluated next cycle.

Transitions:
- RUN → MEM_WAIT when mem_stall. wait_cnt is cleared to 1.
- MEM_WAIT → RUN when dmem_ready. While MEM_WAIT and !dmem_ready, wait_cnt increments.
- When wait_cnt reaches MEM_TIMEOUT: mem_timeout_err is set (sticky until reset), FSM forces RUN, and wait_cnt clears. Freeze still follows mem_stall combinationally.

**Counters:**
- stall_cnt increments in RUN/MEM_WAIT on each cycle with pc_write == 0.
- flush_cnt increments on each cycle with if_id_flush == 1.
- Both saturate at all-ones and never wrap.

## Timing
- All control and forward outputs are combinational from inputs plus state, settling within the same cycle. No registered latency.
- State, boot_cnt, wait_cnt, counters and mem_timeout_err update on posedge clk.
- Reset values: state BOOT, all counters 0, mem_timeout_err 0. Outputs are therefore pc_write 0, IF_ID_write 0, ID_EX_bubble 1, if_id_flush 0, pipe_freeze 0, forwards 00.
- Reset asserted mid-MEM_WAIT returns to BOOT immediately, with no completion of the pending wait.
- First PC advance occurs BOOT_CYCLES edges after reset release.
- dmem_ready rising in MEM_WAIT releases the freeze in the same cycle.

## Structure
- Shared package core_pkg holds:
  - forward codes FWD_RF / FWD_ALU / FWD_DMEM / FWD_EXMEM;
  - the state enum;
  - the REG_ADDR_WIDTH default.
- One sub-module, fwd_sel, instantiated twice (per operand): pure combinational priority logic.
- FSM, counters and stall logic live in hazard_ctrl.

## Test plan
- **Reset and boot.** Release reset with BOOT_CYCLES = 2 → pc_write 0 for 2 cycles, then 1; ID_EX_bubble 1 → 0.
- **Load-use.** lw x5 in EX, ID uses rs1 = x5 → one cycle of pc_write 0, ID_EX_bubble 1, stall_cnt +1. Next cycle the load is in MEM → forward_comp1 = 10.
- **Forwarding from EX and MEM.** add x7 in EX and ID branch on x7 → forward_comp1 = 01, no stall. Same producer in MEM → 11. rs = x0 with ID_EX_rd = 0 → 00.
- **Simultaneous hazards.** pc_sel = 1 with load_use = 1 → no flush that cycle. Next cycle pc_sel = 1 → if_id_flush = 1, flush_cnt = 1.
- **Memory wait and timeout.** EX_MEM_mem_req = 1 with dmem_ready = 0 for 3 cycles → pipe_freeze 1, pc_write 0 for 3 cycles, released when ready rises. With MEM_TIMEOUT = 4 and ready held low → mem_timeout_err set and sticky.
- **Reset mid-wait and saturation.** Assert reset_n = 0 in MEM_WAIT → state BOOT, counters 0. Preload with CNT_WIDTH = 4 and 20 stall cycles → stall_cnt holds at 15.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the pipeline hazard controller
package core_pkg;
  localparam int DEF_REG_ADDR_WIDTH = 5;
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_ALU   = 2'b01;
  localparam logic [1:0] FWD_DMEM  = 2'b10;
  localparam logic [1:0] FWD_EXMEM = 2'b11;
  typedef enum logic [1:0] {BOOT, RUN, MEM_WAIT} state_t;
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-to-hazard-controller bundle
//   master: pipeline side, drives ID/EX/MEM hazard info, samples controls
//   slave : hazard_ctrl side, drives stall/flush/forward controls and counters
interface hazard_ctrl_if import core_pkg::*; #(
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int CNT_WIDTH = 32
);
  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1, IF_ID_rs2, ID_EX_rd, EX_MEM_rd;
  logic id_uses_rs1, id_uses_rs2;
  logic ID_EX_reg_wr_en, ID_EX_is_load;
  logic EX_MEM_reg_wr_en, EX_MEM_is_load, EX_MEM_mem_req;
  logic dmem_ready, pc_sel;
  logic pc_write, IF_ID_write, ID_EX_bubble, if_id_flush, pipe_freeze;
  logic [1:0] forward_comp1, forward_comp2;
  logic mem_timeout_err;
  logic [CNT_WIDTH-1:0] stall_cnt, flush_cnt;
  modport master (
    output IF_ID_rs1, IF_ID_rs2, id_uses_rs1, id_uses_rs2, ID_EX_reg_wr_en, ID_EX_is_load, ID_EX_rd,
           EX_MEM_reg_wr_en, EX_MEM_is_load, EX_MEM_mem_req, EX_MEM_rd, dmem_ready, pc_sel,
    input  pc_write, IF_ID_write, ID_EX_bubble, if_id_flush, pipe_freeze, forward_comp1, forward_comp2,
           mem_timeout_err, stall_cnt, flush_cnt
  );
  modport slave (
    input  IF_ID_rs1, IF_ID_rs2, id_uses_rs1, id_uses_rs2, ID_EX_reg_wr_en, ID_EX_is_load, ID_EX_rd,
           EX_MEM_reg_wr_en, EX_MEM_is_load, EX_MEM_mem_req, EX_MEM_rd, dmem_ready, pc_sel,
    output pc_write, IF_ID_write, ID_EX_bubble, if_id_flush, pipe_freeze, forward_comp1, forward_comp2,
           mem_timeout_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// fwd_sel: per-operand ID forward select; EX producer beats MEM producer, x0 never forwarded
//   in : rs, EX producer (wr_en/is_load/rd), MEM producer (wr_en/is_load/rd)
//   out: fwd (FWD_RF/FWD_ALU/FWD_DMEM/FWD_EXMEM)
module fwd_sel import core_pkg::*; #(
  parameter int W = DEF_REG_ADDR_WIDTH
) (
  input  logic [W-1:0] rs,
  input  logic         ex_wr_en,
  input  logic         ex_is_load,
  input  logic [W-1:0] ex_rd,
  input  logic         mem_wr_en,
  input  logic         mem_is_load,
  input  logic [W-1:0] mem_rd,
  output logic [1:0]   fwd
);
  // A load in EX has no data yet; it is left to the load-use stall instead.
  always_comb
    fwd = (rs == '0) ? FWD_RF :
          (ex_wr_en && !ex_is_load && ex_rd == rs) ? FWD_ALU :
          (mem_wr_en && mem_rd == rs) ? (mem_is_load ? FWD_DMEM : FWD_EXMEM) : FWD_RF;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward control, boot hold, dmem wait timeout and perf counters
//   clk, reset_n (async, active-low)
//   bus (slave): hazard inputs from ID/EX/MEM, combinational controls, sticky timeout, counters
module hazard_ctrl import core_pkg::*; #(
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int BOOT_CYCLES = 2,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_WIDTH = 32
) (
  input logic clk,
  input logic reset_n,
  hazard_ctrl_if.slave bus
);
  localparam int BW = $clog2(BOOT_CYCLES + 1);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  state_t state, state_nx;
  logic [BW-1:0] boot_cnt;
  logic [WW-1:0] wait_cnt, wait_nx;
  logic err, err_nx;
  logic [CNT_WIDTH-1:0] stall_cnt, flush_cnt;
  logic [1:0] fwd1, fwd2;
  logic boot, mem_stall, load_use, advance;
  fwd_sel #(.W(REG_ADDR_WIDTH)) u_fwd1 (
    .rs(bus.IF_ID_rs1), .ex_wr_en(bus.ID_EX_reg_wr_en), .ex_is_load(bus.ID_EX_is_load), .ex_rd(bus.ID_EX_rd),
    .mem_wr_en(bus.EX_MEM_reg_wr_en), .mem_is_load(bus.EX_MEM_is_load), .mem_rd(bus.EX_MEM_rd), .fwd(fwd1)
  );
  fwd_sel #(.W(REG_ADDR_WIDTH)) u_fwd2 (
    .rs(bus.IF_ID_rs2), .ex_wr_en(bus.ID_EX_reg_wr_en), .ex_is_load(bus.ID_EX_is_load), .ex_rd(bus.ID_EX_rd),
    .mem_wr_en(bus.EX_MEM_reg_wr_en), .mem_is_load(bus.EX_MEM_is_load), .mem_rd(bus.EX_MEM_rd), .fwd(fwd2)
  );
  assign boot      = state == BOOT;
  assign mem_stall = bus.EX_MEM_mem_req & !bus.dmem_ready;
  assign load_use  = bus.ID_EX_is_load & bus.ID_EX_reg_wr_en & (bus.ID_EX_rd != '0) &
                     ((bus.id_uses_rs1 & (bus.IF_ID_rs1 == bus.ID_EX_rd)) |
                      (bus.id_uses_rs2 & (bus.IF_ID_rs2 == bus.ID_EX_rd)));
  assign advance   = !boot & !mem_stall & !load_use;
  assign bus.pc_write        = advance;
  assign bus.IF_ID_write     = advance;
  assign bus.ID_EX_bubble    = boot | (!mem_stall & load_use);
  // A taken branch stalled behind a load is held, not flushed, and re-resolves next cycle.
  assign bus.if_id_flush     = advance & bus.pc_sel;
  assign bus.pipe_freeze     = !boot & mem_stall;
  assign bus.forward_comp1   = boot ? FWD_RF : fwd1;
  assign bus.forward_comp2   = boot ? FWD_RF : fwd2;
  assign bus.mem_timeout_err = err;
  assign bus.stall_cnt       = stall_cnt;
  assign bus.flush_cnt       = flush_cnt;
  always_comb begin
    state_nx = state;
    wait_nx = wait_cnt;
    err_nx = err;
    case (state)
      BOOT: state_nx = (boot_cnt == BW'(BOOT_CYCLES - 1)) ? RUN : BOOT;
      RUN: begin
        state_nx = mem_stall ? MEM_WAIT : RUN;
        wait_nx = mem_stall ? WW'(1) : wait_cnt;
      end
      MEM_WAIT: begin
        // Timeout gives up on the access and returns to RUN; freeze still tracks mem_stall.
        if (bus.dmem_ready) state_nx = RUN;
        else if (wait_cnt == WW'(MEM_TIMEOUT)) begin
          state_nx = RUN;
          wait_nx = '0;
          err_nx = 1'b1;
        end else wait_nx = wait_cnt + 1'b1;
      end
      default: state_nx = BOOT;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= BOOT;
      boot_cnt <= '0;
      wait_cnt <= '0;
      err <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nx;
      boot_cnt <= boot ? boot_cnt + 1'b1 : boot_cnt;
      wait_cnt <= wait_nx;
      err <= err_nx;
      if (!boot && !advance && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (bus.if_id_flush && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed plus random stimulus against a behavioural hazard model
module tb_hazard_ctrl;
  localparam int BOOT = 2;
  localparam int TO = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int boot_left, wcnt, scnt, fcnt;
  bit waiting, err;
  hazard_ctrl_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(CW)) bus ();
  hazard_ctrl #(.REG_ADDR_WIDTH(5), .BOOT_CYCLES(BOOT), .MEM_TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int fwd_of(logic [4:0] rs);
    if (rs == 0) return 0;
    if (bus.ID_EX_reg_wr_en && !bus.ID_EX_is_load && bus.ID_EX_rd == rs) return 1;
    if (bus.EX_MEM_reg_wr_en && bus.EX_MEM_rd == rs) return bus.EX_MEM_is_load ? 2 : 3;
    return 0;
  endfunction

  task automatic model_reset();
    boot_left = BOOT;
    waiting = 0;
    wcnt = 0;
    err = 0;
    scnt = 0;
    fcnt = 0;
  endtask

  task automatic idle();
    bus.IF_ID_rs1 = 0; bus.IF_ID_rs2 = 0; bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0;
    bus.ID_EX_reg_wr_en = 0; bus.ID_EX_is_load = 0; bus.ID_EX_rd = 0;
    bus.EX_MEM_reg_wr_en = 0; bus.EX_MEM_is_load = 0; bus.EX_MEM_mem_req = 0; bus.EX_MEM_rd = 0;
    bus.dmem_ready = 1; bus.pc_sel = 0;
  endtask

  // One clock: compare everything mid-cycle, then advance the model across the edge.
  task automatic cycle();
    bit bt, ms, lu, adv, fl;
    if (!reset_n) model_reset();
    @(negedge clk);
    bt = boot_left > 0;
    ms = bus.EX_MEM_mem_req && !bus.dmem_ready;
    lu = bus.ID_EX_is_load && bus.ID_EX_reg_wr_en && bus.ID_EX_rd != 0 &&
         ((bus.id_uses_rs1 && bus.IF_ID_rs1 == bus.ID_EX_rd) || (bus.id_uses_rs2 && bus.IF_ID_rs2 == bus.ID_EX_rd));
    adv = !bt && !ms && !lu;
    fl = adv && bus.pc_sel;
    chk("pc_write", bus.pc_write, adv);
    chk("if_id_write", bus.IF_ID_write, adv);
    chk("bubble", bus.ID_EX_bubble, bt || (!ms && lu));
    chk("flush", bus.if_id_flush, fl);
    chk("freeze", bus.pipe_freeze, !bt && ms);
    chk("fwd1", bus.forward_comp1, bt ? 0 : fwd_of(bus.IF_ID_rs1));
    chk("fwd2", bus.forward_comp2, bt ? 0 : fwd_of(bus.IF_ID_rs2));
    chk("timeout_err", bus.mem_timeout_err, err);
    chk("stall_cnt", bus.stall_cnt, scnt);
    chk("flush_cnt", bus.flush_cnt, fcnt);
    @(posedge clk);
    if (!reset_n) model_reset();
    else if (bt) boot_left--;
    else begin
      if (!adv && scnt < CMAX) scnt++;
      if (fl && fcnt < CMAX) fcnt++;
      if (!waiting) begin
        if (ms) begin waiting = 1; wcnt = 1; end
      end else if (bus.dmem_ready) waiting = 0;
      else if (wcnt == TO) begin waiting = 0; wcnt = 0; err = 1; end
      else wcnt++;
    end
    #1;
  endtask

  initial begin
    model_reset();
    idle();
    #1;
    cycle();
    cycle();
    reset_n = 1;
    repeat (4) cycle();
    // load-use on x5, then the load reaches MEM
    bus.ID_EX_reg_wr_en = 1; bus.ID_EX_is_load = 1; bus.ID_EX_rd = 5;
    bus.IF_ID_rs1 = 5; bus.id_uses_rs1 = 1;
    cycle();
    chk("lu_stall_cnt", bus.stall_cnt, 1);
    idle();
    bus.EX_MEM_reg_wr_en = 1; bus.EX_MEM_is_load = 1; bus.EX_MEM_rd = 5; bus.EX_MEM_mem_req = 1;
    bus.IF_ID_rs1 = 5; bus.id_uses_rs1 = 1;
    cycle();
    // ALU producer x7 in EX, then in MEM, then x0
    idle();
    bus.ID_EX_reg_wr_en = 1; bus.ID_EX_rd = 7; bus.IF_ID_rs1 = 7; bus.id_uses_rs1 = 1;
    cycle();
    idle();
    bus.EX_MEM_reg_wr_en = 1; bus.EX_MEM_rd = 7; bus.IF_ID_rs2 = 7; bus.id_uses_rs2 = 1;
    cycle();
    idle();
    bus.ID_EX_reg_wr_en = 1; bus.ID_EX_rd = 0; bus.id_uses_rs1 = 1;
    cycle();
    // branch behind a load-use, then re-resolved
    idle();
    bus.ID_EX_reg_wr_en = 1; bus.ID_EX_is_load = 1; bus.ID_EX_rd = 9;
    bus.IF_ID_rs2 = 9; bus.id_uses_rs2 = 1; bus.pc_sel = 1;
    cycle();
    idle();
    bus.pc_sel = 1;
    cycle();
    chk("flush_cnt_one", bus.flush_cnt, 1);
    // 3-cycle memory wait released by ready
    idle();
    bus.EX_MEM_mem_req = 1; bus.dmem_ready = 0;
    repeat (3) cycle();
    bus.dmem_ready = 1;
    cycle();
    // ready held low past the timeout; error is sticky
    bus.dmem_ready = 0;
    repeat (7) cycle();
    chk("err_set", bus.mem_timeout_err, 1);
    idle();
    repeat (2) cycle();
    chk("err_sticky", bus.mem_timeout_err, 1);
    // reset while waiting, then saturate the stall counter
    bus.EX_MEM_mem_req = 1; bus.dmem_ready = 0;
    repeat (2) cycle();
    reset_n = 0;
    cycle();
    chk("rst_err", bus.mem_timeout_err, 0);
    reset_n = 1;
    repeat (BOOT + 20) cycle();
    chk("stall_sat", bus.stall_cnt, CMAX);
    // random traffic with occasional resets
    reset_n = 0;
    idle();
    cycle();
    reset_n = 1;
    for (int i = 0; i < 400; i++) begin
      bus.IF_ID_rs1 = 5'($urandom_range(0, 3));
      bus.IF_ID_rs2 = 5'($urandom_range(0, 3));
      bus.id_uses_rs1 = 1'($urandom);
      bus.id_uses_rs2 = 1'($urandom);
      bus.ID_EX_reg_wr_en = 1'($urandom);
      bus.ID_EX_is_load = 1'($urandom);
      bus.ID_EX_rd = 5'($urandom_range(0, 3));
      bus.EX_MEM_reg_wr_en = 1'($urandom);
      bus.EX_MEM_is_load = 1'($urandom);
      bus.EX_MEM_mem_req = 1'($urandom);
      bus.EX_MEM_rd = 5'($urandom_range(0, 3));
      bus.dmem_ready = $urandom_range(0, 3) != 0;
      bus.pc_sel = 1'($urandom);
      reset_n = $urandom_range(0, 63) != 0;
      cycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
